// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch time base: counts on tick_1hz, per-digit adjust on tick_adj, pause toggle.
// Optional STOPWATCH_HOLD_AT_MAX_EN: saturate at the maximum count instead of wrapping.
module stopwatch_counter #(
  parameter int unsigned MAX_TENS = 5,
  parameter int unsigned MAX_ONES = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_adj,
  input  logic       pause_p,
  input  logic       adj,
  input  logic [1:0] sel,
  output logic [3:0] sec0,
  output logic [2:0] sec1,
  output logic [3:0] min0,
  output logic [2:0] min1,
  output logic       paused,
  output logic       wrap_p
);

  localparam logic [3:0] MaxOnes = 4'(MAX_ONES);
  localparam logic [2:0] MaxTens = 3'(MAX_TENS);

  typedef enum logic [1:0] {StRun, StPause, StAdj} state_e;

  state_e state;
  logic   paused_next;
  logic   at_max;
  logic   hold;

  assign paused_next = paused ^ pause_p;
  assign at_max      = (sec0 == MaxOnes) && (sec1 == MaxTens) &&
                       (min0 == MaxOnes) && (min1 == MaxTens);

`ifdef STOPWATCH_HOLD_AT_MAX_EN
  assign hold = at_max;
`else
  assign hold = 1'b0;
`endif

  // Counting and adjust decisions use the state held at the start of the cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= StRun;
      sec0   <= '0;
      sec1   <= '0;
      min0   <= '0;
      min1   <= '0;
      paused <= 1'b0;
      wrap_p <= 1'b0;
    end else begin
      wrap_p <= 1'b0;
      paused <= paused_next;

      if (adj) begin
        state <= StAdj;
      end else if (paused_next) begin
        state <= StPause;
      end else begin
        state <= StRun;
      end

      if (state == StRun && tick_1hz && !hold) begin
        if (sec0 != MaxOnes) begin
          sec0 <= sec0 + 4'd1;
        end else begin
          sec0 <= '0;
          if (sec1 != MaxTens) begin
            sec1 <= sec1 + 3'd1;
          end else begin
            sec1 <= '0;
            if (min0 != MaxOnes) begin
              min0 <= min0 + 4'd1;
            end else begin
              min0 <= '0;
              if (min1 != MaxTens) begin
                min1 <= min1 + 3'd1;
              end else begin
                min1   <= '0;
                wrap_p <= 1'b1;
              end
            end
          end
        end
      end else if (state == StAdj && tick_adj) begin
        // Each digit wraps within its own range; no carry into neighbours.
        unique case (sel)
          2'd0: sec0 <= (sec0 == MaxOnes) ? 4'd0 : sec0 + 4'd1;
          2'd1: sec1 <= (sec1 == MaxTens) ? 3'd0 : sec1 + 3'd1;
          2'd2: min0 <= (min0 == MaxOnes) ? 4'd0 : min0 + 4'd1;
          2'd3: min1 <= (min1 == MaxTens) ? 3'd0 : min1 + 3'd1;
          default: ;
        endcase
      end
    end
  end

  a_digits_in_range: assert property (@(posedge clk) disable iff (rst)
    (sec0 <= MaxOnes) && (sec1 <= MaxTens) && (min0 <= MaxOnes) && (min1 <= MaxTens));

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: vector table plus multi-cycle sequences.
// Expectations follow STOPWATCH_HOLD_AT_MAX_EN when that macro is defined.
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       tick_adj = 1'b0;
  logic       pause_p = 1'b0;
  logic       adj = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [3:0] sec0;
  logic [2:0] sec1;
  logic [3:0] min0;
  logic [2:0] min1;
  logic       paused;
  logic       wrap_p;

  int n_chk  = 0;
  int n_fail = 0;

  stopwatch_counter #(.MAX_TENS(5), .MAX_ONES(9)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1hz (tick_1hz),
    .tick_adj (tick_adj),
    .pause_p  (pause_p),
    .adj      (adj),
    .sel      (sel),
    .sec0     (sec0),
    .sec1     (sec1),
    .min0     (min0),
    .min1     (min1),
    .paused   (paused),
    .wrap_p   (wrap_p)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, t1, ta, pp, a;
    logic [1:0] s;
    logic [15:0] e;
  } vec_t;

  vec_t tbl[23];

  // Packed view: {paused, wrap_p, min1, min0, sec1, sec0}
  function automatic logic [15:0] ev(input int p, input int w, input int m1, input int m0,
                                     input int s1, input int s0);
    return {1'(p), 1'(w), 3'(m1), 4'(m0), 3'(s1), 4'(s0)};
  endfunction

  function automatic vec_t mk(input int r, input int t1, input int ta, input int pp,
                              input int a, input int s, input logic [15:0] e);
    vec_t v;
    v.r  = 1'(r);
    v.t1 = 1'(t1);
    v.ta = 1'(ta);
    v.pp = 1'(pp);
    v.a  = 1'(a);
    v.s  = 2'(s);
    v.e  = e;
    return v;
  endfunction

  task automatic step(input logic r, input logic t1, input logic ta, input logic pp,
                      input logic a, input logic [1:0] s);
    rst      = r;
    tick_1hz = t1;
    tick_adj = ta;
    pause_p  = pp;
    adj      = a;
    sel      = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] exp);
    logic [15:0] obs;
    obs = {paused, wrap_p, min1, min0, sec1, sec0};
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (p,w,m1,m0,s1,s0 packed)", name, obs, exp);
    end
  endtask

  task automatic adj_ticks(input logic [1:0] s, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, s);
  endtask

  initial begin
    //              r  t1 ta pp a  s   expected p w m1 m0 s1 s0
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0));
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 1));
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 1));
    tbl[3]  = mk(0, 1, 0, 1, 0, 0, ev(1, 0, 0, 0, 0, 2));
    tbl[4]  = mk(0, 1, 0, 0, 0, 0, ev(1, 0, 0, 0, 0, 2));
    tbl[5]  = mk(0, 1, 0, 1, 0, 0, ev(0, 0, 0, 0, 0, 2));
    tbl[6]  = mk(0, 1, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 3));
    tbl[7]  = mk(0, 0, 0, 0, 1, 0, ev(0, 0, 0, 0, 0, 3));
    tbl[8]  = mk(0, 1, 1, 0, 1, 0, ev(0, 0, 0, 0, 0, 4));
    tbl[9]  = mk(0, 0, 1, 0, 1, 3, ev(0, 0, 1, 0, 0, 4));
    tbl[10] = mk(0, 0, 1, 0, 1, 2, ev(0, 0, 1, 1, 0, 4));
    tbl[11] = mk(0, 0, 1, 0, 1, 1, ev(0, 0, 1, 1, 1, 4));
    tbl[12] = mk(0, 0, 0, 1, 1, 1, ev(1, 0, 1, 1, 1, 4));
    tbl[13] = mk(0, 1, 0, 0, 1, 1, ev(1, 0, 1, 1, 1, 4));
    tbl[14] = mk(0, 1, 0, 0, 0, 1, ev(1, 0, 1, 1, 1, 4));
    tbl[15] = mk(0, 1, 0, 0, 0, 1, ev(1, 0, 1, 1, 1, 4));
    tbl[16] = mk(0, 0, 0, 1, 0, 1, ev(0, 0, 1, 1, 1, 4));
    tbl[17] = mk(0, 1, 0, 0, 0, 1, ev(0, 0, 1, 1, 1, 5));
    tbl[18] = mk(0, 0, 0, 0, 1, 0, ev(0, 0, 1, 1, 1, 5));
    tbl[19] = mk(1, 1, 1, 1, 1, 0, ev(0, 0, 0, 0, 0, 0));
    tbl[20] = mk(0, 0, 1, 0, 1, 0, ev(0, 0, 0, 0, 0, 0));
    tbl[21] = mk(0, 0, 1, 0, 1, 0, ev(0, 0, 0, 0, 0, 1));
    tbl[22] = mk(0, 0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 1));

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].r, tbl[i].t1, tbl[i].ta, tbl[i].pp, tbl[i].a, tbl[i].s);
      check($sformatf("vec%0d", i), tbl[i].e);
    end

    // Ten counts from reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    check("reset", ev(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    end
    check("count10", ev(0, 0, 0, 0, 1, 0));

    // Pause freezes digits; pause_p with tick in RUN counts first
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    check("pause_on", ev(1, 0, 0, 0, 1, 0));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    check("frozen", ev(1, 0, 0, 0, 1, 0));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    check("pause_off", ev(0, 0, 0, 0, 1, 0));
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    check("tick_then_pause", ev(1, 0, 0, 0, 1, 1));
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    check("paused_after", ev(1, 0, 0, 0, 1, 1));

    // Preload 00:59, carry into minutes without wrap
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    adj_ticks(2'd1, 5);
    adj_ticks(2'd0, 9);
    check("preload_0059", ev(0, 0, 0, 0, 5, 9));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    check("carry_0100", ev(0, 0, 0, 1, 0, 0));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    check("no_wrap_0100", ev(0, 0, 0, 1, 0, 0));

    // Preload 59:59 from 01:00, then one count
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    adj_ticks(2'd0, 9);
    adj_ticks(2'd1, 5);
    adj_ticks(2'd2, 8);
    adj_ticks(2'd3, 5);
    check("preload_5959", ev(0, 0, 5, 9, 5, 9));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
`ifdef STOPWATCH_HOLD_AT_MAX_EN
    check("hold_max", ev(0, 0, 5, 9, 5, 9));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    check("hold_max_next", ev(0, 0, 5, 9, 5, 9));
`else
    check("wrap", ev(0, 1, 0, 0, 0, 0));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    check("wrap_1cycle", ev(0, 0, 0, 0, 0, 0));
`endif

    // Adjust sec1 seven times from 0 with sec0 preset to 3
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    adj_ticks(2'd0, 3);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
      check($sformatf("adj_sec1_%0d", i), ev(0, 0, 0, 0, (i + 1) % 6, 3));
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
    check("tick_in_adj", ev(0, 0, 0, 0, 1, 3));
    adj_ticks(2'd0, 7);
    check("sec0_wrap_nocarry", ev(0, 0, 0, 0, 1, 0));

    // Build 37:42 in ADJ, pause, then reset
    adj_ticks(2'd3, 3);
    adj_ticks(2'd2, 7);
    adj_ticks(2'd1, 3);
    adj_ticks(2'd0, 2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    check("preload_3742", ev(1, 0, 3, 7, 4, 2));
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    check("rst_in_adj", ev(0, 0, 0, 0, 0, 0));
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    check("post_rst_run", ev(0, 0, 0, 0, 0, 0));
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    check("post_rst_adj", ev(0, 0, 0, 0, 0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
